// File: rtl/ila_trace_pkg.sv
// ila_trace_pkg: state encoding and trigger-mode constants shared by the trace unit.
package ila_trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        TM_IMM          = 2'd0,
        TM_EXT          = 2'd1,
        TM_MATCH        = 2'd2,
        TM_EXT_OR_MATCH = 2'd3
    } trig_mode_e;

endpackage

// File: rtl/trace_ram.sv
// trace_ram: one probe channel buffer, synchronous write and registered read-before-write readback.
module trace_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata <= mem_q[raddr];
    end

endmodule

// File: rtl/ila_trace_unit.sv
// ila_trace_unit: multi-channel logic-analyser capture with armed trigger, post-trigger window
// and circular-buffer readback relative to the oldest stored sample.
module ila_trace_unit
    import ila_trace_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 2,
    parameter int DEPTH_LOG2 = 9,
    localparam int CW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         arm,
    input  logic                         clear,
    input  logic [1:0]                   trig_mode,
    input  logic                         trig_in,
    input  logic [DATA_WIDTH-1:0]        match_val,
    input  logic [DATA_WIDTH-1:0]        match_mask,
    input  logic [DEPTH_LOG2:0]          post_count,
    input  logic [NUM_CH*DATA_WIDTH-1:0] probe_data,
    input  logic                         probe_valid,
    input  logic [DEPTH_LOG2-1:0]        rd_addr,
    input  logic [CW-1:0]                rd_ch,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [1:0]                   state,
    output logic [DEPTH_LOG2-1:0]        start_ptr,
    output logic [DEPTH_LOG2-1:0]        trig_ptr,
    output logic [DEPTH_LOG2:0]          sample_count,
    output logic                         done
);

    localparam int DEPTH = 2**DEPTH_LOG2;

    state_e                       state_q, state_d;
    trig_mode_e                   mode_q, mode_d;
    logic [DEPTH_LOG2-1:0]        wr_ptr_q, wr_ptr_d, trig_q, trig_d;
    logic [DEPTH_LOG2:0]          cnt_q, cnt_d, rem_q, rem_d, post_q, post_d, rem_load;
    logic [DATA_WIDTH-1:0]        mval_q, mval_d, mask_q, mask_d, rd_mux;
    logic [CW-1:0]                rd_sel_q;
    logic                         rd_ok_q, we, hit, hit_match;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] ram_rd;

    // arm/clear/reset cycles never write, so an abort leaves the buffer intact
    assign we = reset && !clear && !arm && probe_valid
             && (state_q == S_ARMED || state_q == S_CAPTURE);

    assign hit_match = ((probe_data[DATA_WIDTH-1:0] ^ mval_q) & mask_q) == '0;
    assign hit = (mode_q == TM_IMM)
              || (mode_q == TM_EXT && trig_in)
              || (mode_q == TM_MATCH && hit_match)
              || (mode_q == TM_EXT_OR_MATCH && (trig_in || hit_match));

    assign rem_load = (post_q == '0) ? '0
                    : (post_q > (DEPTH_LOG2+1)'(DEPTH)) ? (DEPTH_LOG2+1)'(DEPTH - 1)
                    : post_q - 1'b1;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        trig_d   = trig_q;
        mode_d   = mode_q;
        mval_d   = mval_q;
        mask_d   = mask_q;
        post_d   = post_q;
        if (clear) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            cnt_d    = '0;
            rem_d    = '0;
            trig_d   = '0;
        end else if (arm) begin
            state_d  = S_ARMED;
            wr_ptr_d = '0;
            cnt_d    = '0;
            rem_d    = '0;
            trig_d   = '0;
            mode_d   = trig_mode_e'(trig_mode);
            mval_d   = match_val;
            mask_d   = match_mask;
            post_d   = post_count;
        end else if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_d    = cnt_q[DEPTH_LOG2] ? cnt_q : cnt_q + 1'b1;
            if (state_q == S_ARMED && hit) begin
                trig_d  = wr_ptr_q;
                rem_d   = rem_load;
                state_d = (rem_load == '0) ? S_DONE : S_CAPTURE;
            end else if (state_q == S_CAPTURE) begin
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == (DEPTH_LOG2+1)'(1)) ? S_DONE : S_CAPTURE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            trig_q   <= '0;
            mode_q   <= TM_IMM;
            mval_q   <= '0;
            mask_q   <= '0;
            post_q   <= '0;
            rd_sel_q <= '0;
            rd_ok_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            trig_q   <= trig_d;
            mode_q   <= mode_d;
            mval_q   <= mval_d;
            mask_q   <= mask_d;
            post_q   <= post_d;
            rd_sel_q <= rd_ch;
            rd_ok_q  <= int'(rd_ch) < NUM_CH;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        trace_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (wr_ptr_q),
            .wdata (probe_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .raddr (start_ptr + rd_addr),
            .rdata (ram_rd[k])
        );
    end

    // rd_ok_q also forces zero straight out of reset
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (rd_ok_q && int'(rd_sel_q) == k) rd_mux = ram_rd[k];
    end

    assign rd_data      = rd_mux;
    assign state        = state_q;
    assign start_ptr    = cnt_q[DEPTH_LOG2] ? wr_ptr_q : '0;
    assign trig_ptr     = trig_q;
    assign sample_count = cnt_q;
    assign done         = state_q == S_DONE;

endmodule

// File: doc/ila_trace_unit.md
ILA_TRACE_UNIT -- requirements
Module: ila_trace_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, shall set the width of one probe channel sample.
REQ-002 Parameter NUM_CH, default 2, shall set the number of probe channels captured in lockstep.
REQ-003 Parameter DEPTH_LOG2, default 9, shall set buffer depth DEPTH = 2**DEPTH_LOG2 samples per channel.
REQ-004 The ports shall be as follows; the module shall have one clock, and reset shall be synchronous and active-low.
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- arm  in  1  single-cycle pulse that starts a capture.
- clear  in  1  single-cycle pulse that aborts to IDLE.
- trig_mode  in  2  0 immediate, 1 external trig_in, 2 pattern match, 3 trig_in OR match.
- trig_in  in  1  external trigger level.
- match_val  in  DATA_WIDTH  pattern compared against channel 0.
- match_mask  in  DATA_WIDTH  1 = bit compared.
- post_count  in  DEPTH_LOG2+1  samples to store from the trigger onward, trigger included.
- probe_data  in  NUM_CH*DATA_WIDTH  channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
- probe_valid  in  1  sample strobe.
- rd_addr  in  DEPTH_LOG2  logical offset from the oldest stored sample.
- rd_ch  in  max(1,clog2(NUM_CH))  channel select for readback.
- rd_data  out  DATA_WIDTH  registered readback data.
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE.
- start_ptr  out  DEPTH_LOG2  physical address of the oldest sample.
- trig_ptr  out  DEPTH_LOG2  physical address of the trigger sample.
- sample_count  out  DEPTH_LOG2+1  valid samples stored; saturates at DEPTH.
- done  out  1  high while state is DONE.

Function
REQ-005 IDLE shall perform no writes; arm shall move to ARMED with wr_ptr=0 and sample_count=0, and shall latch trig_mode, match_val, match_mask and post_count.
REQ-006 In ARMED and CAPTURE, each cycle with probe_valid=1 shall write all NUM_CH channels at wr_ptr, advance wr_ptr modulo DEPTH (wrapping DEPTH-1 to 0), and increment sample_count saturating at DEPTH.
REQ-007 A trigger shall be evaluated only in ARMED on a probe_valid cycle: mode 0 on any sample; mode 1 if trig_in=1; mode 2 if ((ch0 XOR match_val) AND match_mask) = 0; mode 3 if mode 1 OR mode 2.
REQ-008 On a trigger the trigger sample shall be written, trig_ptr shall take the current wr_ptr, and the block shall load remaining = min(post_count,DEPTH) - 1.
REQ-009 After a trigger, if remaining = 0 (including post_count 0 or 1) the next state shall be DONE; otherwise it shall be CAPTURE.
REQ-010 In CAPTURE each written sample shall decrement remaining, and the write that takes remaining from 1 to 0 shall be followed by DONE on the next cycle.
REQ-011 DONE shall perform no writes and hold all status; done=1.
REQ-012 arm in ARMED, CAPTURE or DONE shall restart as in REQ-005.
REQ-013 clear shall return to IDLE with pointers and counts zeroed, shall take priority over arm, and shall leave memory contents unchanged.
REQ-014 start_ptr shall be 0 while sample_count < DEPTH and shall equal wr_ptr otherwise.
REQ-015 rd_data shall equal mem[rd_ch][(start_ptr + rd_addr) mod DEPTH] one cycle after rd_addr/rd_ch are presented, in any state; rd_ch >= NUM_CH shall return 0.
REQ-016 A readback of the same address in the cycle it is written shall return the old data (read-before-write).

Reset
REQ-017 When reset=0 on a clock edge: state=IDLE, wr_ptr=0, remaining=0, sample_count=0, start_ptr=0, trig_ptr=0, done=0, rd_data=0; memory shall not be initialised.
REQ-018 Reset asserted mid-capture shall abort the capture with no further writes from the next edge.

Structure
REQ-019 Package ila_trace_pkg shall hold the state encoding and the trig_mode constants.
REQ-020 Sub-module trace_ram (DATA_WIDTH x DEPTH, one synchronous write port, one synchronous read port) shall be instantiated NUM_CH times.

Verification (DEPTH_LOG2=4, NUM_CH=2)
REQ-021 Mode 0, post_count=4, arm, 4 valid samples 0xA0..0xA3 -> DONE, trig_ptr=0, sample_count=4, rd_addr 0..3 return 0xA0..0xA3.
REQ-022 Mode 1, post_count=4, 20 samples 0..19 with trig_in at sample 17, then 2 more samples -> samples 17..20 stored, sample_count=16, start_ptr=5, rd_addr 0 returns 5.
REQ-023 Mode 2, match_val=0x55, match_mask=0xFF, ch0 receives 0x15 then 0x55 -> trigger on 0x55 only; probe_valid=0 cycles cause neither a trigger nor a write.
REQ-024 post_count=0 and post_count=31 -> DONE immediately after the trigger and clamping to 16 samples, respectively.
REQ-025 clear and arm together in CAPTURE -> IDLE; reset=0 in CAPTURE -> all REQ-017 values and memory unchanged.
REQ-026 rd_ch=1 returns channel 1 data; rd_ch=1 with NUM_CH=1 returns 0; a same-cycle read/write returns the old data.
